// File: rtl/conv_pkg.sv
// Shared definitions for the convolution controller: FSM state encoding,
// default widths and watchdog length, and an index-width helper.
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOADK,
        ST_LOADX,
        ST_CLR,
        ST_RUN,
        ST_COLLECT,
        ST_DRAIN
    } state_t;

    localparam int DEF_DATA_W         = 8;
    localparam int DEF_RES_W          = 20;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    // Bits needed to address `depth` entries (at least one bit).
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/conv_rbuf.sv
// Result buffer: RESULT_NUM x RES_W storage with one synchronous write port
// and one combinational read port addressed by index.
module conv_rbuf
    import conv_pkg::*;
#(
    parameter int DEPTH = 5,
    parameter int RES_W = DEF_RES_W,
    parameter int IW    = idx_w(DEPTH)
) (
    input  logic             Aclk,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_idx,
    input  logic [RES_W-1:0] wr_data,
    input  logic [IW-1:0]    rd_idx,
    output logic [RES_W-1:0] rd_data
);

    logic [RES_W-1:0] mem [DEPTH];

    always_ff @(posedge Aclk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/conv_ctrl.sv
// Convolution job controller: loads kernel and pattern, streams operands to
// the datapath, collects results and drains them. Watchdog: CONV_CTRL_TIMEOUT_EN.
module conv_ctrl
    import conv_pkg::*;
#(
    parameter int PATTERN_NUM = 8,
    parameter int KERNEL_NUM  = 4,
    parameter int RESULT_NUM  = PATTERN_NUM - KERNEL_NUM + 1,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int RES_W       = DEF_RES_W
`ifdef CONV_CTRL_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic              Aclk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              conv_clr,
    output logic [DATA_W-1:0] conv_xin,
    output logic [DATA_W-1:0] conv_kin,
    input  logic [RES_W-1:0]  conv_rout,
    input  logic              conv_rdone,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int LOAD_MAX = (PATTERN_NUM > KERNEL_NUM) ? PATTERN_NUM : KERNEL_NUM;
    localparam int CW       = $clog2(LOAD_MAX + 1);
    localparam int KIW      = idx_w(KERNEL_NUM);
    localparam int PIW      = idx_w(PATTERN_NUM);
    localparam int RIW      = idx_w(RESULT_NUM);
    localparam int RCW      = $clog2(RESULT_NUM + 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nx;
    logic [KIW-1:0]    kidx;
    logic [KIW-1:0]    kidx_nx;
    logic [RCW-1:0]    rcnt;
    logic [RIW-1:0]    rd;
    logic              beat;
    logic              capture;
    logic              rbuf_we;
    logic              rcnt_full;
    logic [RES_W-1:0]  rbuf_rdata;

    logic [DATA_W-1:0] kbuf [KERNEL_NUM];
    logic [DATA_W-1:0] xbuf [PATTERN_NUM];

`ifdef CONV_CTRL_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] wd;
`endif

    assign beat    = in_valid & in_ready;
    assign cnt_nx  = cnt + CW'(1);
    assign kidx_nx = (kidx == KIW'(KERNEL_NUM - 1)) ? '0 : kidx + KIW'(1);

    // Results are only accepted while the datapath is live; surplus beats are dropped.
    assign capture   = ((state == ST_RUN) || (state == ST_COLLECT)) && conv_rdone;
    assign rbuf_we   = capture && (rcnt < RCW'(RESULT_NUM));
    assign rcnt_full = (rcnt == RCW'(RESULT_NUM)) ||
                       (rbuf_we && (rcnt == RCW'(RESULT_NUM - 1)));

    // Operand buffers carry data only; they are simply overwritten by the next job.
    always_ff @(posedge Aclk) begin
        if (beat && (state == ST_LOADK)) begin
            kbuf[cnt[KIW-1:0]] <= in_data;
        end
        if (beat && (state == ST_LOADX)) begin
            xbuf[cnt[PIW-1:0]] <= in_data;
        end
    end

    conv_rbuf #(
        .DEPTH (RESULT_NUM),
        .RES_W (RES_W),
        .IW    (RIW)
    ) u_rbuf (
        .Aclk    (Aclk),
        .wr_en   (rbuf_we),
        .wr_idx  (rcnt[RIW-1:0]),
        .wr_data (conv_rout),
        .rd_idx  (rd),
        .rd_data (rbuf_rdata)
    );

    assign res_data = res_valid ? rbuf_rdata : '0;

`ifndef CONV_CTRL_TIMEOUT_EN
    assign err = 1'b0;
`endif

    always_ff @(posedge Aclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            kidx      <= '0;
            rcnt      <= '0;
            rd        <= '0;
            conv_clr  <= 1'b1;
            in_ready  <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            conv_xin  <= '0;
            conv_kin  <= '0;
`ifdef CONV_CTRL_TIMEOUT_EN
            err       <= 1'b0;
            wd        <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (rbuf_we) begin
                rcnt <= rcnt + RCW'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_LOADK;
                        cnt      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
`ifdef CONV_CTRL_TIMEOUT_EN
                        err      <= 1'b0;
`endif
                    end
                end

                ST_LOADK: begin
                    if (beat) begin
                        if (cnt == CW'(KERNEL_NUM - 1)) begin
                            cnt   <= '0;
                            state <= ST_LOADX;
                        end else begin
                            cnt <= cnt_nx;
                        end
                    end
                end

                ST_LOADX: begin
                    if (beat) begin
                        if (cnt == CW'(PATTERN_NUM - 1)) begin
                            cnt      <= '0;
                            in_ready <= 1'b0;
                            state    <= ST_CLR;
                        end else begin
                            cnt <= cnt_nx;
                        end
                    end
                end

                // conv_clr has been high since IDLE; CLR is its final cycle.
                ST_CLR: begin
                    state    <= ST_RUN;
                    conv_clr <= 1'b0;
                    cnt      <= '0;
                    kidx     <= '0;
                    rcnt     <= '0;
                    conv_xin <= xbuf[0];
                    conv_kin <= kbuf[0];
                end

                // Operands for the next run cycle are registered one cycle ahead.
                ST_RUN: begin
                    if (cnt == CW'(PATTERN_NUM - 1)) begin
                        state    <= ST_COLLECT;
                        conv_xin <= '0;
                        conv_kin <= '0;
`ifdef CONV_CTRL_TIMEOUT_EN
                        wd       <= '0;
`endif
                    end else begin
                        cnt      <= cnt_nx;
                        kidx     <= kidx_nx;
                        conv_xin <= xbuf[cnt_nx[PIW-1:0]];
                        conv_kin <= kbuf[kidx_nx];
                    end
                end

                ST_COLLECT: begin
                    if (rcnt_full) begin
                        state     <= ST_DRAIN;
                        res_valid <= 1'b1;
                        rd        <= '0;
                    end
`ifdef CONV_CTRL_TIMEOUT_EN
                    else if (conv_rdone) begin
                        wd <= '0;
                    end else if (wd == WDW'(TIMEOUT_CYCLES - 1)) begin
                        state    <= ST_IDLE;
                        err      <= 1'b1;
                        busy     <= 1'b0;
                        conv_clr <= 1'b1;
                    end else begin
                        wd <= wd + WDW'(1);
                    end
`endif
                end

                ST_DRAIN: begin
                    if (res_ready) begin
                        if (rd == RIW'(RESULT_NUM - 1)) begin
                            state     <= ST_IDLE;
                            res_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            conv_clr  <= 1'b1;
                            rd        <= '0;
                        end else begin
                            rd <= rd + RIW'(1);
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_ctrl.sv
// Bench for conv_ctrl: a behavioural convolution datapath sits behind the
// controller and a reference model predicts every result and operand.
module tb_conv_ctrl;

    localparam int P  = 8;
    localparam int K  = 4;
    localparam int R  = P - K + 1;
    localparam int DW = 8;
    localparam int RW = 20;
`ifdef CONV_CTRL_TIMEOUT_EN
    localparam int TO = 40;
`endif

    logic          Aclk      = 1'b0;
    logic          rst_n     = 1'b0;
    logic          start     = 1'b0;
    logic          in_valid  = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          res_ready = 1'b1;
    logic          in_ready, conv_clr, conv_rdone, res_valid, busy, done, err;
    logic [DW-1:0] conv_xin, conv_kin;
    logic [RW-1:0] conv_rout, res_data;

    always #5 Aclk = ~Aclk;

    conv_ctrl #(
        .PATTERN_NUM (P),
        .KERNEL_NUM  (K),
        .DATA_W      (DW),
        .RES_W       (RW)
`ifdef CONV_CTRL_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TO)
`endif
    ) dut (
        .Aclk       (Aclk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .conv_clr   (conv_clr),
        .conv_xin   (conv_xin),
        .conv_kin   (conv_kin),
        .conv_rout  (conv_rout),
        .conv_rdone (conv_rdone),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural datapath: takes one (x,k) pair per cycle while clr is low,
    // emits one windowed dot product per cycle once K samples are in.
    int            dp_n     = 0;
    logic          dp_rdone = 1'b0;
    logic [RW-1:0] dp_rout  = '0;
    logic [DW-1:0] dp_xs [P];
    logic [DW-1:0] dp_ks [K];
    bit            kill     = 1'b0;

    function automatic logic [RW-1:0] dp_sum(input int n, input logic [DW-1:0] xin,
                                             input logic [DW-1:0] kin);
        int s = 0;
        for (int t = 0; t < K; t++) begin
            int xi = n - K + 1 + t;
            int xv = (xi == n) ? int'(xin) : int'(dp_xs[xi]);
            int kv = (t == n % K) ? int'(kin) : int'(dp_ks[t]);
            s += xv * kv;
        end
        return RW'(s);
    endfunction

    always @(posedge Aclk) begin
        if (conv_clr) begin
            dp_n     <= 0;
            dp_rdone <= 1'b0;
        end else if (dp_n < P) begin
            dp_xs[dp_n]     <= conv_xin;
            dp_ks[dp_n % K] <= conv_kin;
            dp_rdone        <= (dp_n >= K - 1);
            dp_rout         <= dp_sum(dp_n, conv_xin, conv_kin);
            dp_n            <= dp_n + 1;
        end else begin
            dp_rdone <= 1'b0;
        end
    end

    assign conv_rdone = dp_rdone & ~kill;
    assign conv_rout  = dp_rout;

    // Reference model: the job's inputs and the results they must produce.
    logic [DW-1:0] cur_k [K];
    logic [DW-1:0] cur_x [P];
    logic [RW-1:0] exp_r [R];
    logic [RW-1:0] got_r [R];
    int            got_cnt  = 0;
    bit            final_hs = 1'b0;
    int            done_cnt = 0;
    int            ready_mode = 0;
    int            lit [R] = '{10, 14, 18, 22, 26};

    function automatic void model();
        for (int j = 0; j < R; j++) begin
            int s = 0;
            for (int t = 0; t < K; t++) s += int'(cur_k[t]) * int'(cur_x[j + t]);
            exp_r[j] = RW'(s);
        end
    endfunction

    initial forever begin
        @(posedge Aclk);
        #1;
        case (ready_mode)
            0:       res_ready = 1'b1;
            1:       res_ready = ~res_ready;
            default: res_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Per-cycle compare against the model.
    initial forever begin
        @(negedge Aclk);
        if (rst_n) begin
            chk("done_pulse", done, final_hs);
            if (done) done_cnt++;
            final_hs = 1'b0;
            if (res_valid) begin
                chk("in_ready_in_drain", in_ready, 0);
                if (got_cnt < R) begin
                    chk("res_data", res_data, exp_r[got_cnt]);
                    if (res_ready) begin
                        got_r[got_cnt] = res_data;
                        got_cnt++;
                        if (got_cnt == R) final_hs = 1'b1;
                    end
                end else begin
                    chk("res_extra_beat", got_cnt, R - 1);
                end
            end
            if (conv_clr || dp_n >= P) begin
                chk("xin_idle", conv_xin, 0);
                chk("kin_idle", conv_kin, 0);
            end else begin
                chk("xin_run", conv_xin, cur_x[dp_n]);
                chk("kin_run", conv_kin, cur_k[dp_n % K]);
            end
`ifndef CONV_CTRL_TIMEOUT_EN
            chk("err_tied", err, 0);
`endif
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_clr"}, conv_clr, 1);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_xin"}, conv_xin, 0);
        chk({tag, "_kin"}, conv_kin, 0);
        chk({tag, "_res_data"}, res_data, 0);
    endtask

    task automatic run_job(input int gap_mode, input bit start_in_run,
                           input int rst_cycle, input bit expect_to);
        int  d0 = done_cnt;
        bit  pulsed = 1'b0;
        bit  finished = 1'b0;
        bit  was_reset = 1'b0;
        model();
        got_cnt  = 0;
        final_hs = 1'b0;
        @(posedge Aclk); #1 start = 1'b1;
        @(posedge Aclk); #1 start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("in_ready_load", in_ready, 1);
`ifdef CONV_CTRL_TIMEOUT_EN
        chk("err_cleared_by_start", err, 0);
`endif
        for (int i = 0; i < K + P; i++) begin
            int w = 0;
            if ((gap_mode == 1 && i % 2 == 1) || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
                in_valid = 1'b0;
                in_data  = DW'($urandom);
                @(posedge Aclk); #1;
            end
            in_valid = 1'b1;
            in_data  = (i < K) ? cur_k[i] : cur_x[i - K];
            forever begin
                @(negedge Aclk);
                if (in_ready) break;
                w++;
                if (w > 20) begin
                    $display("FAIL load_handshake: in_ready stuck at %0d, expected 1", in_ready);
                    $fatal(1, "load stalled");
                end
            end
            @(posedge Aclk); #1;
        end
        in_valid = 1'b0;

        for (int c = 0; c < 300 && !finished; c++) begin
            @(negedge Aclk);
            if (!res_valid && !done) chk("in_ready_after_load", in_ready, 0);
            if (rst_cycle >= 0 && !conv_clr && dp_n == rst_cycle) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("midjob_reset");
                @(posedge Aclk); #2;
                got_cnt  = 0;
                final_hs = 1'b0;
                rst_n    = 1'b1;
                was_reset = 1'b1;
                finished  = 1'b1;
            end else if (done || (expect_to && !busy)) begin
                finished = 1'b1;
            end else if (start_in_run && !pulsed && !conv_clr && dp_n == 1) begin
                pulsed = 1'b1;
                start  = 1'b1;
                @(posedge Aclk); #1 start = 1'b0;
            end
        end
        chk("job_completes_in_bound", finished, 1);

        if (was_reset) begin
            repeat (3) @(negedge Aclk);
            chk("reset_no_done", done_cnt - d0, 0);
            chk("reset_idle_busy", busy, 0);
        end else if (expect_to) begin
            chk("timeout_err", err, 1);
            chk("timeout_busy", busy, 0);
            chk("timeout_results", got_cnt, 0);
            repeat (5) @(negedge Aclk);
            chk("timeout_err_held", err, 1);
            chk("timeout_no_done", done_cnt - d0, 0);
        end else begin
            chk("busy_at_done", busy, 0);
            repeat (3) @(negedge Aclk);
            chk("one_done_pulse", done_cnt - d0, 1);
            chk("result_count", got_cnt, R);
            chk("idle_busy", busy, 0);
        end
    endtask

    task automatic basic_job();
        for (int t = 0; t < K; t++) cur_k[t] = 8'd1;
        for (int i = 0; i < P; i++) cur_x[i] = DW'(i + 1);
    endtask

    task automatic pin_literals(input string tag);
        for (int j = 0; j < R; j++) begin
            chk({tag, "_model"}, exp_r[j], lit[j]);
            chk({tag, "_dut"}, got_r[j], lit[j]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1, "global timeout");
    end

    initial begin
        repeat (2) @(posedge Aclk);
        #1;
        check_reset_outputs("reset");
        #1 rst_n = 1'b1;
        repeat (2) @(posedge Aclk);

        basic_job();
        run_job(0, 1'b0, -1, 1'b0);
        pin_literals("ones_basic");

        ready_mode = 1;
        run_job(0, 1'b0, -1, 1'b0);
        pin_literals("ones_toggle_ready");
        ready_mode = 0;

        run_job(1, 1'b0, -1, 1'b0);
        pin_literals("ones_gapped_load");

        run_job(0, 1'b1, -1, 1'b0);
        pin_literals("ones_start_in_run");

        run_job(0, 1'b0, 3, 1'b0);
        run_job(0, 1'b0, -1, 1'b0);
        pin_literals("ones_after_reset");

        ready_mode = 2;
        for (int n = 0; n < 10; n++) begin
            for (int t = 0; t < K; t++) cur_k[t] = DW'($urandom);
            for (int i = 0; i < P; i++) cur_x[i] = DW'($urandom);
            if (n == 0) begin
                for (int t = 0; t < K; t++) cur_k[t] = 8'hFF;
                for (int i = 0; i < P; i++) cur_x[i] = 8'hFF;
            end
            run_job(2, n[0], -1, 1'b0);
        end
        ready_mode = 0;

`ifdef CONV_CTRL_TIMEOUT_EN
        basic_job();
        kill = 1'b1;
        run_job(0, 1'b0, -1, 1'b1);
        kill = 1'b0;
        run_job(0, 1'b0, -1, 1'b0);
        pin_literals("ones_after_timeout");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
